// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-side AXI read path: request type codes,
// default AXI IDs, AR FSM states and the request-type to AR-field mapping.
package cache_axi_pkg;

  localparam logic [2:0] RD_BYTE = 3'b000;
  localparam logic [2:0] RD_HALF = 3'b001;
  localparam logic [2:0] RD_WORD = 3'b010;
  localparam logic [2:0] RD_LINE = 3'b100;

  localparam logic [3:0] DEF_ID_IC = 4'd0;
  localparam logic [3:0] DEF_ID_DC = 4'd1;

  localparam int unsigned LINE_BEATS = 4;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic       line;
  } ar_fmt_t;

  // Unrecognised type codes fall back to a single-word read.
  function automatic ar_fmt_t map_rd_type(input logic [2:0] rd_type);
    ar_fmt_t fmt;
    fmt.len  = 8'd0;
    fmt.size = 3'd2;
    fmt.line = 1'b0;
    case (rd_type)
      RD_BYTE: fmt.size = 3'd0;
      RD_HALF: fmt.size = 3'd1;
      RD_WORD: fmt.size = 3'd2;
      RD_LINE: begin
        fmt.len  = 8'(LINE_BEATS - 1);
        fmt.line = 1'b1;
      end
      default: fmt.size = 3'd2;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/cache_rd_arbiter_rr_arb2.sv
// Two-requester round-robin grant. The pointer remembers which requester was
// served last and only moves when the caller reports a completed issue.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_upd,
  input  logic i_upd_src,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 0: requester 0 was granted last, 1: requester 1 was granted last.
  logic r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b0;
    end else if (i_upd) begin
      r_last <= i_upd_src;
    end
  end

  always_comb begin
    o_gnt0 = i_req0 & (~i_req1 | r_last);
    o_gnt1 = i_req1 & (~i_req0 | ~r_last);
  end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read address/data path between icache and dcache: serialises
// requests onto AR with per-source IDs and steers R beats back by rid.
module cache_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] ID_IC = DEF_ID_IC,
  parameter logic [3:0] ID_DC = DEF_ID_DC
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ic_rd_req,
  input  logic [2:0]  ic_rd_type,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  output logic        ic_ret_valid,
  output logic        ic_ret_last,
  output logic [31:0] ic_ret_data,

  input  logic        dc_rd_req,
  input  logic [2:0]  dc_rd_type,
  input  logic [31:0] dc_rd_addr,
  output logic        dc_rd_rdy,
  output logic        dc_ret_valid,
  output logic        dc_ret_last,
  output logic [31:0] dc_ret_data,

  input  logic        wr_pend,
  input  logic [31:0] wr_pend_addr,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  ar_state_e   r_state;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic        r_src_dc;
  logic        r_out_ic;
  logic        r_out_dc;

  logic        w_dc_hazard;
  logic        w_ic_elig;
  logic        w_dc_elig;
  logic        w_gnt_ic;
  logic        w_gnt_dc;
  logic        w_idle;
  logic        w_acc_ic;
  logic        w_acc_dc;
  logic        w_accept;
  logic        w_ar_hs;
  logic        w_ic_hit;
  logic        w_dc_hit;
  logic        w_out_ic_d;
  logic        w_out_dc_d;
  logic [2:0]  w_req_type;
  logic [31:0] w_req_addr;
  logic [31:0] w_ar_addr;
  ar_fmt_t     w_fmt;

  // A dcache read of the same 16-byte line as a pending write must wait.
  assign w_dc_hazard = wr_pend && (wr_pend_addr[31:4] == dc_rd_addr[31:4]);
  assign w_ic_elig   = ic_rd_req && !r_out_ic;
  assign w_dc_elig   = dc_rd_req && !r_out_dc && !w_dc_hazard;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .i_req0    (w_ic_elig),
    .i_req1    (w_dc_elig),
    .i_upd     (w_ar_hs),
    .i_upd_src (r_src_dc),
    .o_gnt0    (w_gnt_ic),
    .o_gnt1    (w_gnt_dc)
  );

  assign w_idle    = (r_state == AR_IDLE) && !reset;
  assign ic_rd_rdy = w_idle && w_gnt_ic;
  assign dc_rd_rdy = w_idle && w_gnt_dc;

  assign w_acc_ic  = ic_rd_req && ic_rd_rdy;
  assign w_acc_dc  = dc_rd_req && dc_rd_rdy;
  assign w_accept  = w_acc_ic || w_acc_dc;
  assign w_ar_hs   = (r_state == AR_BUSY) && arready;

  always_comb begin
    w_req_type = ic_rd_type;
    w_req_addr = ic_rd_addr;
    if (w_acc_dc) begin
      w_req_type = dc_rd_type;
      w_req_addr = dc_rd_addr;
    end
    w_fmt     = map_rd_type(w_req_type);
    w_ar_addr = w_req_addr;
    if (w_fmt.line) begin
      w_ar_addr = {w_req_addr[31:4], 4'b0000};
    end
  end

  assign w_ic_hit = rvalid && (rid == ID_IC);
  assign w_dc_hit = rvalid && (rid == ID_DC);

  // Issue sets a source's bit, its last beat clears it; the two never coincide
  // because a source is only issued while its bit is clear.
  always_comb begin
    w_out_ic_d = r_out_ic;
    w_out_dc_d = r_out_dc;
    if (w_ic_hit && rlast) begin
      w_out_ic_d = 1'b0;
    end
    if (w_dc_hit && rlast) begin
      w_out_dc_d = 1'b0;
    end
    if (w_ar_hs && !r_src_dc) begin
      w_out_ic_d = 1'b1;
    end
    if (w_ar_hs && r_src_dc) begin
      w_out_dc_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= AR_IDLE;
      r_arid   <= 4'd0;
      r_araddr <= 32'd0;
      r_arlen  <= 8'd0;
      r_arsize <= 3'd0;
      r_src_dc <= 1'b0;
      r_out_ic <= 1'b0;
      r_out_dc <= 1'b0;
    end else begin
      r_out_ic <= w_out_ic_d;
      r_out_dc <= w_out_dc_d;
      unique case (r_state)
        AR_IDLE: begin
          if (w_accept) begin
            r_state  <= AR_BUSY;
            r_arid   <= w_acc_dc ? ID_DC : ID_IC;
            r_araddr <= w_ar_addr;
            r_arlen  <= w_fmt.len;
            r_arsize <= w_fmt.size;
            r_src_dc <= w_acc_dc;
          end
        end
        AR_BUSY: begin
          if (arready) begin
            r_state <= AR_IDLE;
          end
        end
        default: r_state <= AR_IDLE;
      endcase
    end
  end

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arvalid = (r_state == AR_BUSY);

  assign rready       = 1'b1;
  assign ic_ret_valid = w_ic_hit;
  assign ic_ret_last  = w_ic_hit && rlast;
  assign ic_ret_data  = rdata;
  assign dc_ret_valid = w_dc_hit;
  assign dc_ret_last  = w_dc_hit && rlast;
  assign dc_ret_data  = rdata;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter: arbitration, type mapping, RAW hazard,
// R-beat steering, AR backpressure and mid-transfer reset.
module tb_cache_rd_arbiter;

  logic        clk;
  logic        reset;
  logic        ic_rd_req;
  logic [2:0]  ic_rd_type;
  logic [31:0] ic_rd_addr;
  logic        ic_rd_rdy;
  logic        ic_ret_valid;
  logic        ic_ret_last;
  logic [31:0] ic_ret_data;
  logic        dc_rd_req;
  logic [2:0]  dc_rd_type;
  logic [31:0] dc_rd_addr;
  logic        dc_rd_rdy;
  logic        dc_ret_valid;
  logic        dc_ret_last;
  logic [31:0] dc_ret_data;
  logic        wr_pend;
  logic [31:0] wr_pend_addr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] rid_v  [6] = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
  logic       last_v [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  cache_rd_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .ic_rd_req    (ic_rd_req),
    .ic_rd_type   (ic_rd_type),
    .ic_rd_addr   (ic_rd_addr),
    .ic_rd_rdy    (ic_rd_rdy),
    .ic_ret_valid (ic_ret_valid),
    .ic_ret_last  (ic_ret_last),
    .ic_ret_data  (ic_ret_data),
    .dc_rd_req    (dc_rd_req),
    .dc_rd_type   (dc_rd_type),
    .dc_rd_addr   (dc_rd_addr),
    .dc_rd_rdy    (dc_rd_rdy),
    .dc_ret_valid (dc_ret_valid),
    .dc_ret_last  (dc_ret_last),
    .dc_ret_data  (dc_ret_data),
    .wr_pend      (wr_pend),
    .wr_pend_addr (wr_pend_addr),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single dcache read: check grant, AR fields, a dropped stray-rid beat, then the real beat.
  task automatic do_dc_read(input logic [2:0] t, input logic [31:0] a, input logic [2:0] es,
                            input logic [7:0] el, input logic [31:0] ea);
    dc_rd_req  = 1'b1;
    dc_rd_type = t;
    dc_rd_addr = a;
    #1;
    chk("ty_dc_rdy", dc_rd_rdy, 1);
    step();
    dc_rd_req = 1'b0;
    #1;
    chk("ty_arsize", arsize, es);
    chk("ty_arlen", arlen, el);
    chk("ty_araddr", araddr, ea);
    chk("ty_arid", arid, 4'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rid     = 4'd7;
    rlast   = 1'b1;
    #1;
    chk("drop_ic_valid", ic_ret_valid, 0);
    chk("drop_dc_valid", dc_ret_valid, 0);
    step();
    rid = 4'd1;
    #1;
    chk("ty_dc_last", dc_ret_last, 1);
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    ic_rd_req    = 1'b0;
    ic_rd_type   = 3'b000;
    ic_rd_addr   = 32'd0;
    dc_rd_req    = 1'b0;
    dc_rd_type   = 3'b000;
    dc_rd_addr   = 32'd0;
    wr_pend      = 1'b0;
    wr_pend_addr = 32'd0;
    arready      = 1'b0;
    rid          = 4'd0;
    rdata        = 32'd0;
    rlast        = 1'b0;
    rvalid       = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 1);
    chk("rst_ic_rdy", ic_rd_rdy, 0);
    chk("rst_araddr", araddr, 0);

    // icache line read
    ic_rd_req  = 1'b1;
    ic_rd_type = 3'b100;
    ic_rd_addr = 32'h1C00_0014;
    #1;
    chk("t1_ic_rdy", ic_rd_rdy, 1);
    chk("t1_dc_rdy", dc_rd_rdy, 0);
    step();
    ic_rd_req = 1'b0;
    #1;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1C00_0010);
    chk("t1_arlen", arlen, 3);
    chk("t1_arsize", arsize, 2);
    chk("t1_arid", arid, 0);
    chk("t1_busy_rdy", ic_rd_rdy, 0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    chk("t1_arvalid_low", arvalid, 0);
    ic_rd_req  = 1'b1;
    ic_rd_type = 3'b010;
    ic_rd_addr = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1;
      rid    = 4'd0;
      rdata  = 32'hA000_0000 + i;
      rlast  = (i == 3);
      #1;
      chk("t1_ic_valid", ic_ret_valid, 1);
      chk("t1_dc_valid", dc_ret_valid, 0);
      chk("t1_ic_data", ic_ret_data, 32'hA000_0000 + i);
      chk("t1_ic_last", ic_ret_last, (i == 3));
      chk("t1_outstanding_rdy", ic_rd_rdy, 0);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    #1;
    chk("t1_regrant_after_last", ic_rd_rdy, 1);
    ic_rd_req = 1'b0;

    reset = 1'b1;
    step();
    reset = 1'b0;

    // simultaneous requests after reset: dcache wins first tie
    dc_rd_req  = 1'b1;
    dc_rd_type = 3'b010;
    dc_rd_addr = 32'h0000_1008;
    ic_rd_req  = 1'b1;
    ic_rd_type = 3'b100;
    ic_rd_addr = 32'h1C00_0000;
    #1;
    chk("t2_dc_rdy", dc_rd_rdy, 1);
    chk("t2_ic_rdy", ic_rd_rdy, 0);
    step();
    dc_rd_req = 1'b0;
    #1;
    chk("t2_arid_dc", arid, 1);
    chk("t2_arlen_dc", arlen, 0);
    chk("t2_araddr_dc", araddr, 32'h0000_1008);
    chk("t2_busy_ic_rdy", ic_rd_rdy, 0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    chk("t2_arvalid_low", arvalid, 0);
    chk("t2_ic_rdy_next", ic_rd_rdy, 1);
    step();
    ic_rd_req = 1'b0;
    #1;
    chk("t2_arid_ic", arid, 0);
    chk("t2_araddr_ic", araddr, 32'h1C00_0000);
    chk("t2_arlen_ic", arlen, 3);
    arready = 1'b1;
    step();
    arready = 1'b0;

    // interleaved returns with both reads outstanding
    for (int i = 0; i < 6; i++) begin
      rvalid = 1'b1;
      rid    = rid_v[i];
      rlast  = last_v[i];
      rdata  = 32'h0000_00B0 + i;
      #1;
      chk("t3_ic_valid", ic_ret_valid, (rid_v[i] == 4'd0));
      chk("t3_dc_valid", dc_ret_valid, (rid_v[i] == 4'd1));
      chk("t3_ic_last", ic_ret_last, (rid_v[i] == 4'd0) && last_v[i]);
      chk("t3_dc_last", dc_ret_last, (rid_v[i] == 4'd1) && last_v[i]);
      chk("t3_dc_data", dc_ret_data, 32'h0000_00B0 + i);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;

    // last grant was icache, so the next tie goes to dcache
    ic_rd_req = 1'b1;
    dc_rd_req = 1'b1;
    #1;
    chk("t3_tie_dc_rdy", dc_rd_rdy, 1);
    chk("t3_tie_ic_rdy", ic_rd_rdy, 0);
    ic_rd_req = 1'b0;
    step();
    dc_rd_req = 1'b0;
    arready   = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rid     = 4'd1;
    rlast   = 1'b1;
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;

    // last grant now dcache, so the tie goes to icache
    ic_rd_req = 1'b1;
    dc_rd_req = 1'b1;
    #1;
    chk("t3_tie2_ic_rdy", ic_rd_rdy, 1);
    chk("t3_tie2_dc_rdy", dc_rd_rdy, 0);
    step();
    ic_rd_req = 1'b0;
    dc_rd_req = 1'b0;
    #1;
    chk("t3_tie2_arid", arid, 0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rid     = 4'd0;
    rlast   = 1'b1;
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;

    // RAW hazard blocks dcache, icache granted instead
    wr_pend      = 1'b1;
    wr_pend_addr = 32'h0000_2040;
    dc_rd_req    = 1'b1;
    dc_rd_type   = 3'b010;
    dc_rd_addr   = 32'h0000_204C;
    ic_rd_req    = 1'b1;
    ic_rd_type   = 3'b010;
    ic_rd_addr   = 32'h0000_0300;
    #1;
    chk("t4_dc_blocked", dc_rd_rdy, 0);
    chk("t4_ic_granted", ic_rd_rdy, 1);
    step();
    ic_rd_req = 1'b0;
    #1;
    chk("t4_arid_ic", arid, 0);
    chk("t4_araddr_ic", araddr, 32'h0000_0300);
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    chk("t4_dc_still_blocked", dc_rd_rdy, 0);
    wr_pend = 1'b0;
    #1;
    chk("t4_dc_same_cycle", dc_rd_rdy, 1);
    step();
    #1;
    chk("t4_arid_dc", arid, 1);
    chk("t4_araddr_dc", araddr, 32'h0000_204C);

    // AR backpressure: fields stable, no grants while busy
    dc_rd_addr = 32'hDEAD_0000;
    dc_rd_type = 3'b100;
    ic_rd_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_arvalid", arvalid, 1);
      chk("t5_araddr", araddr, 32'h0000_204C);
      chk("t5_arlen", arlen, 0);
      chk("t5_ic_rdy", ic_rd_rdy, 0);
      chk("t5_dc_rdy", dc_rd_rdy, 0);
      step();
    end

    // reset mid-burst
    rvalid = 1'b1;
    rid    = 4'd0;
    rlast  = 1'b0;
    reset  = 1'b1;
    step();
    reset     = 1'b0;
    rvalid    = 1'b0;
    ic_rd_req = 1'b0;
    dc_rd_req = 1'b0;
    #1;
    chk("t5_rst_arvalid", arvalid, 0);
    chk("t5_rst_rready", rready, 1);
    chk("t5_rst_araddr", araddr, 0);
    dc_rd_type = 3'b010;
    dc_rd_addr = 32'h0000_1008;
    ic_rd_req  = 1'b1;
    dc_rd_req  = 1'b1;
    #1;
    chk("t5_rst_dc_first", dc_rd_rdy, 1);
    chk("t5_rst_ic_wait", ic_rd_rdy, 0);
    dc_rd_req = 1'b0;
    #1;
    chk("t5_rst_ic_cleared", ic_rd_rdy, 1);
    ic_rd_req = 1'b0;
    step();

    // type mapping
    do_dc_read(3'b000, 32'h0000_1003, 3'd0, 8'd0, 32'h0000_1003);
    do_dc_read(3'b001, 32'h0000_1006, 3'd1, 8'd0, 32'h0000_1006);
    do_dc_read(3'b111, 32'h0000_1008, 3'd2, 8'd0, 32'h0000_1008);
    do_dc_read(3'b100, 32'h0000_100C, 3'd2, 8'd3, 32'h0000_1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
